// File: rtl/ghr_checkpoint_ctrl.sv
// Speculative/architectural global-history controller for a gshare front end.
// Pre-branch history is checkpointed per predicted branch and restored on mispredict.
module ghr_checkpoint_ctrl #(
  parameter int G_WIDTH = 7,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               predValid,
  input  logic               predTaken,
  input  logic [G_WIDTH:0]   PC,
  output logic [G_WIDTH:0]   index,
  output logic               allocReady,
  output logic [TAG_W-1:0]   allocTag,
  input  logic               resValid,
  input  logic [TAG_W-1:0]   resTag,
  input  logic               resTaken,
  input  logic               resMispredict,
  input  logic               commitValid,
  output logic [G_WIDTH:0]   specHistory,
  output logic [G_WIDTH:0]   archHistory,
  output logic [TAG_W:0]     count
);

  localparam logic [TAG_W:0] L_FULL = (TAG_W+1)'(DEPTH);

  logic [G_WIDTH:0]              r_spec;
  logic [G_WIDTH:0]              r_arch;
  logic [TAG_W-1:0]              r_head;
  logic [TAG_W-1:0]              r_tail;
  logic [TAG_W:0]                r_count;
  logic [DEPTH-1:0][G_WIDTH:0]   r_saved;
  logic [DEPTH-1:0]              r_outc;

  logic             w_mis;
  logic             w_alloc;
  logic             w_commit;
  logic             w_cout;
  logic [TAG_W-1:0] w_dist;
  logic [TAG_W:0]   w_cnt_nxt;

  assign w_mis      = resValid && resMispredict;
  assign allocReady = (r_count != L_FULL) && !w_mis;
  assign allocTag   = r_tail;
  assign w_alloc    = predValid && allocReady;
  assign w_commit   = commitValid && (r_count != '0);
  // A branch resolving as mispredicted while it retires must retire the corrected outcome.
  assign w_cout     = (w_mis && (resTag == r_head)) ? resTaken : r_outc[r_head];
  assign w_dist     = resTag - r_head;

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_mis)
      w_cnt_nxt = {1'b0, w_dist} + (TAG_W+1)'(1) - {{TAG_W{1'b0}}, w_commit};
    else
      w_cnt_nxt = r_count + {{TAG_W{1'b0}}, w_alloc} - {{TAG_W{1'b0}}, w_commit};
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_spec  <= '0;
      r_arch  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_saved <= '0;
      r_outc  <= '0;
    end else begin
      r_count <= w_cnt_nxt;
      if (w_mis) begin
        r_spec         <= {r_saved[resTag][G_WIDTH-1:0], resTaken};
        r_outc[resTag] <= resTaken;
        r_tail         <= resTag + 1'b1;
      end else if (w_alloc) begin
        r_saved[r_tail] <= r_spec;
        r_outc[r_tail]  <= predTaken;
        r_spec          <= {r_spec[G_WIDTH-1:0], predTaken};
        r_tail          <= r_tail + 1'b1;
      end
      if (w_commit) begin
        r_arch <= {r_arch[G_WIDTH-1:0], w_cout};
        r_head <= r_head + 1'b1;
      end
    end
  end

  assign specHistory = r_spec;
  assign archHistory = r_arch;
  assign count       = r_count;
  assign index       = r_spec ^ PC;

endmodule
